// File: rtl/bus_arbiter.sv
// ---------------------------------------------------------------------------
// bus_arbiter
//   Round-robin arbiter between N_MASTERS hart bus masters and one shared
//   slave bus. One transaction is in flight at a time. The granted master's
//   request fields are forwarded to the slave, and the slave ack/read data
//   are routed back to that master only.
//
//   Optional feature macro: ARB_ATOMIC_LOCK_EN
//     When defined, adds the i_m_atomic port and a LOCK state. The LOCK
//     state keeps the grant with a master between the halves of an atomic
//     read-modify-write sequence.
//
//   Ports
//     i_clk, i_rst          clock (rising edge), async active-low reset
//     i_m_bus_en [N]        per-master request, held until that master's ack
//     i_m_wr_en  [N]        per-master write strobe
//     i_m_wr_data[32N]      per-master write data, master k at [32k+31:32k]
//     i_m_addr   [32N]      per-master address, same packing
//     i_m_byte_en[4N]       per-master byte enables, master k at [4k+3:4k]
//     i_m_atomic [N]        per-master atomic flag (ARB_ATOMIC_LOCK_EN only)
//     o_m_ack    [N]        one-hot ack to the granted master
//     o_m_rd_data[32]       read data to all masters, non-zero only with ack
//     o_bus_en, o_wr_en, o_wr_data, o_addr, o_byte_en   slave request side
//     i_ack, i_rd_data      slave response (ack is a single-cycle pulse)
// ---------------------------------------------------------------------------
module bus_arbiter #(
   parameter int N_MASTERS = 2
) (
   input  logic                      i_clk,
   input  logic                      i_rst,
   input  logic [N_MASTERS-1:0]      i_m_bus_en,
   input  logic [N_MASTERS-1:0]      i_m_wr_en,
   input  logic [32*N_MASTERS-1:0]   i_m_wr_data,
   input  logic [32*N_MASTERS-1:0]   i_m_addr,
   input  logic [4*N_MASTERS-1:0]    i_m_byte_en,
`ifdef ARB_ATOMIC_LOCK_EN
   input  logic [N_MASTERS-1:0]      i_m_atomic,
`endif
   output logic [N_MASTERS-1:0]      o_m_ack,
   output logic [31:0]               o_m_rd_data,
   output logic                      o_bus_en,
   output logic                      o_wr_en,
   output logic [31:0]               o_wr_data,
   output logic [31:0]               o_addr,
   output logic [3:0]                o_byte_en,
   input  logic                      i_ack,
   input  logic [31:0]               i_rd_data
);

   localparam int IDX_W = (N_MASTERS > 2) ? 2 : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_MASTERS - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
`ifdef ARB_ATOMIC_LOCK_EN
      ST_LOCK = 2'd2,
`endif
      ST_BUSY = 2'd1
   } state_t;

   state_t           state_q, state_d;
   logic [IDX_W-1:0] grant_q, grant_d;
   logic [IDX_W-1:0] last_q,  last_d;

   logic             found_s;
   logic [IDX_W-1:0] pick_s;
   logic             active_s;
   logic             bus_en_s;
   logic             sel_bus_en_s;
   logic             sel_wr_en_s;
   logic [31:0]      sel_wr_data_s;
   logic [31:0]      sel_addr_s;
   logic [3:0]       sel_byte_en_s;
   logic             sel_atomic_s;

   // Round-robin pick: first requester after the pointer, wrapping at N_MASTERS.
   always_comb begin
      logic [IDX_W-1:0] idx_v;
      found_s = 1'b0;
      pick_s  = '0;
      idx_v   = last_q;
      for (int k = 0; k < N_MASTERS; k++) begin
         idx_v = (idx_v == LAST_IDX) ? '0 : idx_v + 1'b1;
         if (!found_s && i_m_bus_en[idx_v]) begin
            found_s = 1'b1;
            pick_s  = idx_v;
         end else begin
            found_s = found_s;
         end
      end
   end

   // Field mux for the granted master (AND-OR so no priority chain is built).
   always_comb begin
      sel_wr_en_s   = 1'b0;
      sel_wr_data_s = 32'd0;
      sel_addr_s    = 32'd0;
      sel_byte_en_s = 4'd0;
      sel_atomic_s  = 1'b0;
      for (int k = 0; k < N_MASTERS; k++) begin
         sel_wr_en_s   = sel_wr_en_s   | ((grant_q == IDX_W'(k)) & i_m_wr_en[k]);
         sel_wr_data_s = sel_wr_data_s | ({32{grant_q == IDX_W'(k)}} & i_m_wr_data[32*k +: 32]);
         sel_addr_s    = sel_addr_s    | ({32{grant_q == IDX_W'(k)}} & i_m_addr[32*k +: 32]);
         sel_byte_en_s = sel_byte_en_s | ({4{grant_q == IDX_W'(k)}} & i_m_byte_en[4*k +: 4]);
`ifdef ARB_ATOMIC_LOCK_EN
         sel_atomic_s  = sel_atomic_s  | ((grant_q == IDX_W'(k)) & i_m_atomic[k]);
`endif
      end
   end

   assign sel_bus_en_s = i_m_bus_en[grant_q];

`ifdef ARB_ATOMIC_LOCK_EN
   assign active_s = (state_q == ST_BUSY) || (state_q == ST_LOCK);
`else
   assign active_s = (state_q == ST_BUSY);
`endif

   // Next-state logic for the arbitration FSM.
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      last_d  = last_q;
      case (state_q)
         ST_IDLE: begin
            if (found_s) begin
               grant_d = pick_s;
               state_d = ST_BUSY;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_BUSY: begin
            if (i_ack) begin
               last_d = grant_q;
`ifdef ARB_ATOMIC_LOCK_EN
               state_d = sel_atomic_s ? ST_LOCK : ST_IDLE;
`else
               state_d = ST_IDLE;
`endif
            end else if (!sel_bus_en_s) begin
               // Abort: the pointer is left alone so the master keeps its turn.
               state_d = ST_IDLE;
            end else begin
               state_d = ST_BUSY;
            end
         end
`ifdef ARB_ATOMIC_LOCK_EN
         ST_LOCK: begin
            // Hold the grant until the owner is neither atomic nor requesting.
            if (!sel_atomic_s && !sel_bus_en_s) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_LOCK;
            end
         end
`endif
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State, grant and round-robin pointer registers.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state_q <= ST_IDLE;
         grant_q <= '0;
         last_q  <= LAST_IDX;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         last_q  <= last_d;
      end
   end

   // Slave-side outputs: granted master's fields, gated by its request.
   assign bus_en_s  = active_s & sel_bus_en_s;
   assign o_bus_en  = bus_en_s;
   assign o_wr_en   = bus_en_s & sel_wr_en_s;
   assign o_wr_data = {32{bus_en_s}} & sel_wr_data_s;
   assign o_addr    = {32{bus_en_s}} & sel_addr_s;
   assign o_byte_en = {4{bus_en_s}} & sel_byte_en_s;

   // Ack routing: only the granted master sees the slave ack; stray acks vanish.
   always_comb begin
      o_m_ack          = '0;
      o_m_ack[grant_q] = active_s & i_ack;
   end

   assign o_m_rd_data = (active_s & i_ack) ? i_rd_data : 32'd0;

endmodule

// File: tb/tb_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_bus_arbiter
//   Self-checking bench for bus_arbiter with two masters: a directed vector
//   table, hand-written reset/lock sequences, and a randomized run compared
//   against a transaction-level round-robin model.
// ---------------------------------------------------------------------------
module tb_bus_arbiter;
   localparam int N = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic [N-1:0]  m_bus_en;
   logic [N-1:0]  m_wr_en;
   logic [32*N-1:0] m_wr_data;
   logic [32*N-1:0] m_addr;
   logic [4*N-1:0]  m_byte_en;
   logic [N-1:0]  m_atomic;
   logic [N-1:0]  m_ack;
   logic [31:0]   m_rd_data;
   logic          bus_en;
   logic          wr_en;
   logic [31:0]   wr_data;
   logic [31:0]   addr;
   logic [3:0]    byte_en;
   logic          ack;
   logic [31:0]   rd_data;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   bus_arbiter #(.N_MASTERS(N)) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_m_bus_en  (m_bus_en),
      .i_m_wr_en   (m_wr_en),
      .i_m_wr_data (m_wr_data),
      .i_m_addr    (m_addr),
      .i_m_byte_en (m_byte_en),
`ifdef ARB_ATOMIC_LOCK_EN
      .i_m_atomic  (m_atomic),
`endif
      .o_m_ack     (m_ack),
      .o_m_rd_data (m_rd_data),
      .o_bus_en    (bus_en),
      .o_wr_en     (wr_en),
      .o_wr_data   (wr_data),
      .o_addr      (addr),
      .o_byte_en   (byte_en),
      .i_ack       (ack),
      .i_rd_data   (rd_data)
   );

   typedef struct {
      logic [1:0]  m_en;
      logic [1:0]  m_wr;
      logic        ack;
      logic [31:0] rd;
      int          own;    // master whose fields must appear on the slave, -1 = none
      logic [1:0]  e_ack;
      logic [31:0] e_rd;
   } vec_t;

   vec_t tbl[25];
   vec_t atb[9];

   function automatic vec_t mk(input logic [1:0] m_en, input logic [1:0] m_wr,
                               input logic a, input logic [31:0] rd, input int own,
                               input logic [1:0] e_ack, input logic [31:0] e_rd);
      vec_t v;
      v.m_en = m_en; v.m_wr = m_wr; v.ack = a; v.rd = rd;
      v.own = own; v.e_ack = e_ack; v.e_rd = e_rd;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic eb, input logic ew,
                          input logic [31:0] ewd, input logic [31:0] ea,
                          input logic [3:0] ebe, input logic [1:0] emack,
                          input logic [31:0] erd);
      chk({tag, ".bus_en"},  32'(bus_en),  32'(eb));
      chk({tag, ".wr_en"},   32'(wr_en),   32'(ew));
      chk({tag, ".wr_data"}, wr_data,      ewd);
      chk({tag, ".addr"},    addr,         ea);
      chk({tag, ".byte_en"}, 32'(byte_en), 32'(ebe));
      chk({tag, ".m_ack"},   32'(m_ack),   32'(emack));
      chk({tag, ".rd_data"}, m_rd_data,    erd);
   endtask

   // Directed rows use fixed fields: m0 @0x100 data AAAA0000 be F, m1 @0x2000 data 12345678 be 3.
   task automatic apply_row(input vec_t v, input string tag);
      logic        eb, ew;
      logic [31:0] ea, ewd;
      logic [3:0]  ebe;
      @(negedge clk);
      m_bus_en = v.m_en;
      m_wr_en  = v.m_wr;
      ack      = v.ack;
      rd_data  = v.rd;
      #1;
      eb  = (v.own >= 0);
      ea  = (v.own == 1) ? 32'h0000_2000 : (v.own == 0) ? 32'h0000_0100 : 32'd0;
      ewd = (v.own == 1) ? 32'h1234_5678 : (v.own == 0) ? 32'hAAAA_0000 : 32'd0;
      ebe = (v.own == 1) ? 4'b0011 : (v.own == 0) ? 4'b1111 : 4'b0000;
      ew  = (v.own == 1) ? v.m_wr[1] : (v.own == 0) ? v.m_wr[0] : 1'b0;
      chk_all(tag, eb, ew, ewd, ea, ebe, v.e_ack, v.e_rd);
   endtask

   initial begin
      int          own;
      int          rr;
      logic [1:0]  acked;
      logic        eb, ew;
      logic [31:0] ea, ewd, erd;
      logic [3:0]  ebe;
      logic [1:0]  emack;

      // Directed table: read, write, stray ack, simultaneous requests, fairness, abort.
      tbl[0]  = mk(2'b01, 2'b00, 1'b0, 32'd0,          -1, 2'b00, 32'd0);
      tbl[1]  = mk(2'b01, 2'b00, 1'b0, 32'd0,           0, 2'b00, 32'd0);
      tbl[2]  = mk(2'b01, 2'b00, 1'b0, 32'd0,           0, 2'b00, 32'd0);
      tbl[3]  = mk(2'b01, 2'b00, 1'b1, 32'hDEAD_BEEF,   0, 2'b01, 32'hDEAD_BEEF);
      tbl[4]  = mk(2'b00, 2'b00, 1'b0, 32'd0,          -1, 2'b00, 32'd0);
      tbl[5]  = mk(2'b10, 2'b10, 1'b0, 32'd0,          -1, 2'b00, 32'd0);
      tbl[6]  = mk(2'b10, 2'b10, 1'b0, 32'd0,           1, 2'b00, 32'd0);
      tbl[7]  = mk(2'b10, 2'b10, 1'b1, 32'h0000_0055,   1, 2'b10, 32'h0000_0055);
      tbl[8]  = mk(2'b00, 2'b00, 1'b1, 32'h0000_0077,  -1, 2'b00, 32'd0);
      tbl[9]  = mk(2'b11, 2'b00, 1'b0, 32'd0,          -1, 2'b00, 32'd0);
      tbl[10] = mk(2'b11, 2'b00, 1'b0, 32'd0,           0, 2'b00, 32'd0);
      tbl[11] = mk(2'b11, 2'b00, 1'b1, 32'h0000_0001,   0, 2'b01, 32'h0000_0001);
      tbl[12] = mk(2'b10, 2'b00, 1'b0, 32'd0,          -1, 2'b00, 32'd0);
      tbl[13] = mk(2'b10, 2'b00, 1'b0, 32'd0,           1, 2'b00, 32'd0);
      tbl[14] = mk(2'b10, 2'b00, 1'b1, 32'h0000_0002,   1, 2'b10, 32'h0000_0002);
      tbl[15] = mk(2'b11, 2'b00, 1'b0, 32'd0,          -1, 2'b00, 32'd0);
      tbl[16] = mk(2'b11, 2'b00, 1'b0, 32'd0,           0, 2'b00, 32'd0);
      tbl[17] = mk(2'b10, 2'b00, 1'b0, 32'd0,          -1, 2'b00, 32'd0);
      tbl[18] = mk(2'b11, 2'b00, 1'b0, 32'd0,          -1, 2'b00, 32'd0);
      tbl[19] = mk(2'b11, 2'b00, 1'b0, 32'd0,           0, 2'b00, 32'd0);
      tbl[20] = mk(2'b11, 2'b00, 1'b1, 32'h0000_0003,   0, 2'b01, 32'h0000_0003);
      tbl[21] = mk(2'b10, 2'b00, 1'b0, 32'd0,          -1, 2'b00, 32'd0);
      tbl[22] = mk(2'b10, 2'b00, 1'b0, 32'd0,           1, 2'b00, 32'd0);
      tbl[23] = mk(2'b10, 2'b00, 1'b1, 32'h0000_0004,   1, 2'b10, 32'h0000_0004);
      tbl[24] = mk(2'b00, 2'b00, 1'b0, 32'd0,          -1, 2'b00, 32'd0);

      // Lock sequence rows (m_atomic for each row set alongside in the loop below).
      atb[0] = mk(2'b01, 2'b00, 1'b0, 32'd0,         -1, 2'b00, 32'd0);
      atb[1] = mk(2'b11, 2'b00, 1'b0, 32'd0,          0, 2'b00, 32'd0);
      atb[2] = mk(2'b11, 2'b00, 1'b1, 32'h0000_00A1,  0, 2'b01, 32'h0000_00A1);
      atb[3] = mk(2'b10, 2'b00, 1'b0, 32'd0,         -1, 2'b00, 32'd0);
      atb[4] = mk(2'b11, 2'b01, 1'b0, 32'd0,          0, 2'b00, 32'd0);
      atb[5] = mk(2'b11, 2'b01, 1'b1, 32'h0000_00A2,  0, 2'b01, 32'h0000_00A2);
      atb[6] = mk(2'b10, 2'b00, 1'b0, 32'd0,         -1, 2'b00, 32'd0);
      atb[7] = mk(2'b10, 2'b00, 1'b0, 32'd0,         -1, 2'b00, 32'd0);
      atb[8] = mk(2'b10, 2'b00, 1'b0, 32'd0,          1, 2'b00, 32'd0);

      // Reset state: outputs must stay 0 even with requests and an ack present.
      rst       = 1'b0;
      m_bus_en  = 2'b11;
      m_wr_en   = 2'b11;
      m_wr_data = {32'h1234_5678, 32'hAAAA_0000};
      m_addr    = {32'h0000_2000, 32'h0000_0100};
      m_byte_en = {4'b0011, 4'b1111};
      m_atomic  = 2'b00;
      ack       = 1'b1;
      rd_data   = 32'hFFFF_FFFF;
      #1;
      chk_all("in_reset", 1'b0, 1'b0, 32'd0, 32'd0, 4'd0, 2'b00, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1; m_bus_en = 2'b00; m_wr_en = 2'b00; ack = 1'b0; rd_data = 32'd0;
      #1;
      chk_all("post_reset", 1'b0, 1'b0, 32'd0, 32'd0, 4'd0, 2'b00, 32'd0);

      for (int i = 0; i < 25; i++) apply_row(tbl[i], $sformatf("tbl%0d", i));

      // Reset in the middle of an m1 transaction.
      apply_row(mk(2'b10, 2'b00, 1'b0, 32'd0, -1, 2'b00, 32'd0), "mid_rst_a");
      apply_row(mk(2'b10, 2'b00, 1'b0, 32'd0,  1, 2'b00, 32'd0), "mid_rst_b");
      @(negedge clk);
      rst = 1'b0; ack = 1'b1; rd_data = 32'h0000_0009;
      #1;
      chk_all("mid_rst_asserted", 1'b0, 1'b0, 32'd0, 32'd0, 4'd0, 2'b00, 32'd0);
      @(negedge clk);
      rst = 1'b1; m_bus_en = 2'b00; ack = 1'b0;
      #1;
      chk_all("mid_rst_release", 1'b0, 1'b0, 32'd0, 32'd0, 4'd0, 2'b00, 32'd0);
      apply_row(mk(2'b11, 2'b00, 1'b0, 32'd0,         -1, 2'b00, 32'd0),        "after_rst_a");
      apply_row(mk(2'b11, 2'b00, 1'b0, 32'd0,          0, 2'b00, 32'd0),        "after_rst_m0");
      apply_row(mk(2'b11, 2'b00, 1'b1, 32'h0000_00CC,  0, 2'b01, 32'h0000_00CC), "after_rst_ack");
      apply_row(mk(2'b10, 2'b00, 1'b0, 32'd0,         -1, 2'b00, 32'd0),        "after_rst_gap");
      apply_row(mk(2'b10, 2'b00, 1'b1, 32'h0000_00CD,  1, 2'b10, 32'h0000_00CD), "after_rst_m1");
      apply_row(mk(2'b00, 2'b00, 1'b0, 32'd0,         -1, 2'b00, 32'd0),        "after_rst_idle");

`ifdef ARB_ATOMIC_LOCK_EN
      // Atomic pair by m0: m1 must wait until the lock is released.
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 9; i++) begin
         m_atomic = (i < 5) ? 2'b01 : 2'b00;
         apply_row(atb[i], $sformatf("lock%0d", i));
      end
      m_atomic = 2'b00;
`endif

      // Randomized run against a transaction-level round-robin model.
      @(negedge clk);
      rst = 1'b0; m_bus_en = 2'b00; ack = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      own   = -1;
      rr    = N - 1;
      acked = 2'b00;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(negedge clk);
         for (int k = 0; k < N; k++) begin
            if (acked[k]) begin
               m_bus_en[k] = 1'b0;
            end else if (m_bus_en[k]) begin
               if ($urandom_range(0, 29) == 0) m_bus_en[k] = 1'b0;
            end else if ($urandom_range(0, 1) == 0) begin
               m_bus_en[k]           = 1'b1;
               m_wr_en[k]            = 1'($urandom_range(0, 1));
               m_wr_data[32*k +: 32] = $urandom;
               m_addr[32*k +: 32]    = $urandom;
               m_byte_en[4*k +: 4]   = 4'($urandom_range(0, 15));
            end
         end
         ack     = ($urandom_range(0, 3) == 0);
         rd_data = $urandom;
         #1;
         eb = 1'b0; ew = 1'b0; ewd = 32'd0; ea = 32'd0; ebe = 4'd0; emack = 2'b00; erd = 32'd0;
         if (own >= 0) begin
            eb = m_bus_en[own];
            if (eb) begin
               ew  = m_wr_en[own];
               ewd = m_wr_data[32*own +: 32];
               ea  = m_addr[32*own +: 32];
               ebe = m_byte_en[4*own +: 4];
            end
            if (ack) begin
               emack[own] = 1'b1;
               erd        = rd_data;
            end
         end
         chk_all($sformatf("rand%0d", cyc), eb, ew, ewd, ea, ebe, emack, erd);
         acked = emack;
         // Model advance for the coming clock edge.
         if (own < 0) begin
            for (int k = 1; k <= N; k++) begin
               if (m_bus_en[(rr + k) % N]) begin
                  own = (rr + k) % N;
                  break;
               end
            end
         end else if (ack) begin
            rr  = own;
            own = -1;
         end else if (!m_bus_en[own]) begin
            own = -1;
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Round-robin bus arbiter between N hart bus masters and one shared slave bus. It sits directly downstream of each core's bus master port (`bus_en`/`wr_en`/`wr_data`/`addr`/`byte_en`/`ack`/`rd_data`) in multi-core builds and presents a single identical master port to memory. Only one transaction is in flight at a time. Each ack is routed only to the master that owns the grant.

## Interface
- `N_MASTERS`, default 2: number of master ports, legal range 2..4.
- `i_clk` in 1: clock, rising edge.
- `i_rst` in 1: asynchronous, active-low reset.
- `i_m_bus_en` in N: per-master request; held high until that master's ack.
- `i_m_wr_en` in N: per-master write strobe.
- `i_m_wr_data` in 32·N: write data; master k occupies bits [32k+31:32k].
- `i_m_addr` in 32·N: address, packed the same way.
- `i_m_byte_en` in 4·N: byte enables; master k occupies bits [4k+3:4k].
- `o_m_ack` out N: one-hot ack pulse to the granted master.
- `o_m_rd_data` out 32: read data, broadcast to all masters; valid only with the ack.
- `o_bus_en` out 1: slave request.
- `o_wr_en` out 1: slave write strobe.
- `o_wr_data` out 32: slave write data.
- `o_addr` out 32: slave address.
- `o_byte_en` out 4: slave byte enables.
- `i_ack` in 1: slave ack, a single-cycle pulse.
- `i_rd_data` in 32: slave read data, valid with `i_ack`.
- `i_m_atomic` in N: only present with `ARB_ATOMIC_LOCK_EN`.

## Operation
- **State register:** IDLE, BUSY, and LOCK (LOCK exists only with the macro).
- **Grant register:** `grant` is a binary index into the masters. `last` is the round-robin pointer.
- **Reset:** state=IDLE, `grant`=0, `last`=N_MASTERS−1.
- **IDLE:**
  - If any `i_m_bus_en` is high, select the first requester scanning `last+1, last+2, …`, wrapping modulo N_MASTERS.
  - Register it into `grant` and go to BUSY.
  - With no request, stay in IDLE.
- **BUSY:**
  - `o_bus_en` = `i_m_bus_en[grant]`.
  - `o_wr_en`, `o_wr_data`, `o_addr` and `o_byte_en` are the granted master's fields, each ANDed with `o_bus_en`.
  - `o_m_ack[grant]` = `i_ack`.
  - `o_m_rd_data` = `i_rd_data` while `i_ack` is high, otherwise 0.
  - On `i_ack`: `last` ← `grant`, then go to IDLE, or to LOCK per Configuration.
  - If the granted master drops `i_m_bus_en` without an ack (abort), go to IDLE and leave `last` unchanged.
- **Outside BUSY/LOCK:** all slave outputs, `o_m_ack` and `o_m_rd_data` are 0.
- **Stray ack:** `i_ack` arriving in IDLE is ignored and produces no master ack.
- **Master obligation:** masters drop `bus_en` in the cycle after their ack, as the per-core BUS block does. The arbiter does not filter a re-request from a master that fails to do so.

## Timing
- **Reset values:** every output is 0 while `i_rst`=0 and immediately after reset release.
- **Grant latency:** a request seen in IDLE at cycle t produces `o_bus_en`=1 at cycle t+1. This adds 1 cycle to each transaction.
- **Ack path:** `i_ack` → `o_m_ack` and `i_rd_data` → `o_m_rd_data` are combinational, with zero latency.
- **Back-to-back masters:** after an ack at cycle t the FSM is in IDLE at t+1, and the next grant drives `o_bus_en` at t+2. The bus is therefore idle for at least 1 cycle between different masters.
- **Simultaneous requests:** resolved strictly round-robin, so no master waits more than N_MASTERS−1 transactions.
- **Reset mid-transaction:** immediate return to IDLE with all outputs 0. The pending transaction is dropped and no ack is delivered.

## Configuration
- **Macro:** `ARB_ATOMIC_LOCK_EN`.
- **With the macro defined:**
  - The `i_m_atomic` port exists.
  - On ack in BUSY, if `i_m_atomic[grant]`=1, go to LOCK instead of IDLE.
  - In LOCK, `grant` is held and other masters are ignored.
  - In LOCK, outputs and ack routing are the same as in BUSY, so a re-request by the owner reaches the slave in the same cycle.
  - In LOCK, an ack with atomic still 1 stays in LOCK.
  - LOCK exits to IDLE when `i_m_atomic[grant]`=0 and `i_m_bus_en[grant]`=0.
  - This keeps an LR/SC or AMO read-modify-write pair indivisible.
- **Without the macro:** no `i_m_atomic` port, no LOCK state, and every transaction ends in IDLE.

## Test plan
- **Single master read:** reset, then m0 reads addr 0x100; slave acks 3 cycles later with 0xDEADBEEF. Expect `o_bus_en` at t+1, `o_m_ack`=2'b01 for 1 cycle, `o_m_rd_data`=0xDEADBEEF, and m1 ack 0.
- **Simultaneous requests:** m0 and m1 request together after reset. Expect m0 served first, then m1, with `o_bus_en` low for exactly 1 cycle between them.
- **Round-robin fairness:** m1 requests continuously while m0 requests once. Expect the grant to alternate 0,1,1… and never starve m0.
- **Write path:** m1 writes 0x12345678 to 0x2000 with `byte_en`=4'b0011. Expect the slave to see exactly those values and `o_wr_en`=1, and m0 fields to stay masked.
- **Reset mid-transaction:** assert `i_rst`=0 while in BUSY. Expect all outputs 0 the same cycle, and the first grant after release goes to m0.
- **Atomic lock (`ARB_ATOMIC_LOCK_EN`):** m0 issues an LR/SC pair with atomic=1 while m1 requests. Expect m1 to be granted only after m0's second ack with atomic=0.
